// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the transmit framer state type.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StSfd,
    StData,
    StPad,
    StFcs,
    StIfg
  } tx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected) update for one byte, LSB first.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/gmii_mac_tx.sv
// GMII transmit framer: preamble, SFD, payload, zero pad, CRC-32 FCS and inter-frame gap.
module gmii_mac_tx
  import eth_pkg::*;
#(
  parameter int unsigned MIN_PAYLOAD = 60,
  parameter int unsigned IFG_CYCLES  = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       RES,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [10:0] CntMax  = 11'h7FF;
  localparam logic [10:0] MinLen  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] IfgLast = 11'(IFG_CYCLES - 1);

  tx_state_e   state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] cnt_inc;
  logic [31:0] crc_q, crc_d, crc_next;
  logic [7:0]  crc_byte;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        frame_done_q, frame_done_d;
  logic        underrun_q, underrun_d;

  // Byte count saturates rather than wrapping on oversized frames.
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 11'd1;
  assign crc_byte = (state_q == StPad) ? 8'h00 : s_data;

  crc32_d8 u_crc32_d8 (
    .crc_i (crc_q),
    .data_i(crc_byte),
    .crc_o (crc_next)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    crc_d        = crc_q;
    tx_en_d      = 1'b0;
    txd_d        = 8'h00;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          state_d = StPre;
          cnt_d   = '0;
        end
      end
      StPre: begin
        tx_en_d = 1'b1;
        txd_d   = ETH_PREAMBLE;
        cnt_d   = cnt_q + 11'd1;
        if (cnt_q == 11'd6) begin
          state_d = StSfd;
          cnt_d   = '0;
        end
      end
      StSfd: begin
        tx_en_d = 1'b1;
        txd_d   = ETH_SFD;
        crc_d   = CRC32_INIT;
        cnt_d   = '0;
        state_d = StData;
      end
      StData: begin
        if (s_valid) begin
          tx_en_d = 1'b1;
          txd_d   = s_data;
          crc_d   = crc_next;
          cnt_d   = cnt_inc;
          if (s_last) begin
            if (cnt_inc < MinLen) begin
              state_d = StPad;
            end else begin
              state_d = StFcs;
              cnt_d   = '0;
            end
          end
        end else begin
          // Source starved mid-frame: drop tx_en without an FCS.
          underrun_d = 1'b1;
          state_d    = StIfg;
          cnt_d      = '0;
        end
      end
      StPad: begin
        tx_en_d = 1'b1;
        crc_d   = crc_next;
        cnt_d   = cnt_inc;
        if (cnt_inc >= MinLen) begin
          state_d = StFcs;
          cnt_d   = '0;
        end
      end
      StFcs: begin
        tx_en_d = 1'b1;
        txd_d   = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d   = cnt_q + 11'd1;
        if (cnt_q[1:0] == 2'd3) begin
          frame_done_d = 1'b1;
          state_d      = StIfg;
          cnt_d        = '0;
        end
      end
      StIfg: begin
        cnt_d = cnt_q + 11'd1;
        if (cnt_q >= IfgLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or posedge RES) begin
    if (RES) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      crc_q        <= CRC32_INIT;
      tx_en_q      <= 1'b0;
      txd_q        <= 8'h00;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      tx_en_q      <= tx_en_d;
      txd_q        <= txd_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign s_ready    = (state_q == StData);
  assign busy       = (state_q != StIdle);
  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_gmii_mac_tx.sv
// Scoreboard bench for gmii_mac_tx: expected GMII bytes queued at stimulus time, popped on tx_en.
module tb_gmii_mac_tx;
  import eth_pkg::*;

  localparam int MinPayload = 60;
  localparam int IfgCycles  = 12;

  typedef logic [7:0] byte_q_t[$];

  logic       gmii_tx_clk = 1'b0;
  logic       RES;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  gmii_mac_tx #(
    .MIN_PAYLOAD(MinPayload),
    .IFG_CYCLES (IfgCycles)
  ) dut (
    .gmii_tx_clk(gmii_tx_clk),
    .RES        (RES),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .gmii_tx_en (gmii_tx_en),
    .gmii_txd   (gmii_txd),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  int          len_q[$];
  logic [31:0] res_q[$];
  int          fd_cnt = 0;
  int          ur_cnt = 0;
  int          rdy_cnt = 0;
  int          burst_len = 0;
  int          low_run = 0;
  int          last_gap = 0;
  logic        gap_ready = 1'b0;
  logic        last_gap_ready = 1'b0;
  logic        tx_en_prev = 1'b0;
  logic [31:0] run_crc = 32'hFFFFFFFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Monitor: scoreboard pop, burst length, residue, gap length and pulse counts.
  always @(negedge gmii_tx_clk) begin
    if (s_ready) rdy_cnt++;
    if (frame_done) fd_cnt++;
    if (underrun) ur_cnt++;
    if (gmii_tx_en) begin
      if (!tx_en_prev) begin
        last_gap       = low_run;
        last_gap_ready = gap_ready;
        burst_len      = 0;
        run_crc        = 32'hFFFFFFFF;
      end
      if (exp_q.size() == 0) check("txd_extra", 32'(exp_q.size()), 32'd1);
      else check("txd", 32'(gmii_txd), 32'(exp_q.pop_front()));
      if (burst_len >= 8) run_crc = crc_upd(run_crc, gmii_txd);
      burst_len++;
    end else begin
      if (tx_en_prev) begin
        len_q.push_back(burst_len);
        res_q.push_back(run_crc);
        low_run   = 0;
        gap_ready = 1'b0;
      end
      low_run++;
      if (s_ready) gap_ready = 1'b1;
    end
    tx_en_prev = gmii_tx_en;
  end

  task automatic push_hdr();
    repeat (7) exp_q.push_back(ETH_PREAMBLE);
    exp_q.push_back(ETH_SFD);
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge gmii_tx_clk);
    while (!s_ready && n < 500) begin
      @(negedge gmii_tx_clk);
      n++;
    end
    if (!s_ready) check("accept_wait", 32'(s_ready), 32'd1);
    @(posedge gmii_tx_clk);
    #1;
  endtask

  // Sends n_send bytes of pl; a full frame when n_send == pl.size(), else stops short.
  task automatic send_frame(input byte_q_t pl, input int n_send, input bit hold);
    logic [31:0] c;
    int          total;
    push_hdr();
    for (int i = 0; i < n_send; i++) exp_q.push_back(pl[i]);
    if (n_send == pl.size()) begin
      c     = 32'hFFFFFFFF;
      total = (pl.size() < MinPayload) ? MinPayload : pl.size();
      for (int i = 0; i < total; i++) begin
        if (i < pl.size()) c = crc_upd(c, pl[i]);
        else begin
          c = crc_upd(c, 8'h00);
          exp_q.push_back(8'h00);
        end
      end
      c = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(c >> (8 * i)));
    end
    for (int i = 0; i < n_send; i++) begin
      s_valid = 1'b1;
      s_data  = pl[i];
      s_last  = (n_send == pl.size()) && (i == n_send - 1);
      wait_accept();
    end
    s_last  = 1'b0;
    s_valid = hold;
  endtask

  task automatic wait_bursts(input int n);
    int k = 0;
    while (len_q.size() < n && k < 3000) begin
      @(posedge gmii_tx_clk);
      k++;
    end
    #1;
    check("burst_wait", 32'(len_q.size()), 32'(n));
  endtask

  task automatic check_burst(input string tag, input int exp_len, input bit chk_res);
    int          l;
    logic [31:0] r;
    if (len_q.size() > 0) begin
      l = len_q.pop_front();
      r = res_q.pop_front();
      check({tag, "_len"}, 32'(l), 32'(exp_len));
      if (chk_res) check({tag, "_residue"}, r, CRC32_RESIDUE);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge gmii_tx_clk);
      #1;
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic make_payload(input int len, input logic [7:0] base, output byte_q_t pl);
    pl = {};
    for (int i = 0; i < len; i++) pl.push_back(8'(base + 8'(i)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    byte_q_t pl;
    int      fd0, ur0, rdy0;

    RES     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
    #1;
    check("rst_tx_en", 32'(gmii_tx_en), 32'd0);
    check("rst_txd", 32'(gmii_txd), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    repeat (3) @(posedge gmii_tx_clk);
    #1;
    RES = 1'b0;
    repeat (2) @(posedge gmii_tx_clk);
    #1;

    // Exact-minimum frame, no pad.
    fd0 = fd_cnt; rdy0 = rdy_cnt;
    make_payload(60, 8'h00, pl);
    send_frame(pl, 60, 1'b0);
    wait_bursts(1);
    check_burst("s1", 72, 1'b1);
    wait_idle();
    check("s1_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check("s1_ready_cycles", 32'(rdy_cnt - rdy0), 32'd60);
    check("s1_exp_empty", 32'(exp_q.size()), 32'd0);

    // One byte, padded to minimum.
    fd0 = fd_cnt; rdy0 = rdy_cnt;
    pl = {8'hAA};
    send_frame(pl, 1, 1'b0);
    wait_bursts(1);
    check_burst("s2", 72, 1'b1);
    wait_idle();
    check("s2_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check("s2_ready_cycles", 32'(rdy_cnt - rdy0), 32'd1);
    check("s2_exp_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames with s_valid held high through the gap.
    fd0 = fd_cnt;
    make_payload(100, 8'h10, pl);
    send_frame(pl, 100, 1'b1);
    make_payload(100, 8'h80, pl);
    send_frame(pl, 100, 1'b0);
    wait_bursts(2);
    check_burst("s3a", 112, 1'b1);
    check_burst("s3b", 112, 1'b1);
    check("s3_gap_ge13", 32'(last_gap >= IfgCycles + 1), 32'd1);
    check("s3_gap_ready", 32'(last_gap_ready), 32'd0);
    wait_idle();
    check("s3_frame_done", 32'(fd_cnt - fd0), 32'd2);

    // Underrun after byte 30 of a 64-byte frame.
    fd0 = fd_cnt; ur0 = ur_cnt;
    make_payload(64, 8'h40, pl);
    send_frame(pl, 31, 1'b0);
    @(posedge gmii_tx_clk);
    #1;
    check("s4_abort_tx_en", 32'(gmii_tx_en), 32'd0);
    check("s4_abort_txd", 32'(gmii_txd), 32'd0);
    check("s4_underrun", 32'(underrun), 32'd1);
    repeat (IfgCycles - 1) @(posedge gmii_tx_clk);
    #1;
    check("s4_ifg_busy", 32'(busy), 32'd1);
    @(posedge gmii_tx_clk);
    #1;
    check("s4_idle_busy", 32'(busy), 32'd0);
    wait_bursts(1);
    check_burst("s4", 39, 1'b0);
    check("s4_ur_cnt", 32'(ur_cnt - ur0), 32'd1);
    check("s4_fd_cnt", 32'(fd_cnt - fd0), 32'd0);
    make_payload(60, 8'hA0, pl);
    send_frame(pl, 60, 1'b0);
    wait_bursts(1);
    check_burst("s4_next", 72, 1'b1);
    wait_idle();
    check("s4_next_fd", 32'(fd_cnt - fd0), 32'd1);

    // Asynchronous reset in the middle of the FCS.
    make_payload(60, 8'h33, pl);
    send_frame(pl, 60, 1'b0);
    @(posedge gmii_tx_clk);
    @(posedge gmii_tx_clk);
    #1;
    RES = 1'b1;
    exp_q.delete();
    #1;
    check("s5_rst_tx_en", 32'(gmii_tx_en), 32'd0);
    check("s5_rst_txd", 32'(gmii_txd), 32'd0);
    check("s5_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge gmii_tx_clk);
    #1;
    RES = 1'b0;
    len_q.delete();
    res_q.delete();
    @(posedge gmii_tx_clk);
    #1;
    fd0 = fd_cnt;
    make_payload(60, 8'h00, pl);
    send_frame(pl, 60, 1'b0);
    wait_bursts(1);
    check_burst("s5", 72, 1'b1);
    wait_idle();
    check("s5_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // s_valid pulsed in IDLE only: preamble/SFD then abort on first DATA cycle.
    fd0 = fd_cnt; ur0 = ur_cnt;
    push_hdr();
    s_valid = 1'b1;
    s_data  = 8'h5A;
    @(posedge gmii_tx_clk);
    #1;
    s_valid = 1'b0;
    wait_bursts(1);
    check_burst("s6", 8, 1'b0);
    wait_idle();
    check("s6_ur_cnt", 32'(ur_cnt - ur0), 32'd1);
    check("s6_fd_cnt", 32'(fd_cnt - fd0), 32'd0);
    check("s6_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
